uart_mm: RTL and testbench
==========================

// Module: uart_mm
// PURPOSE
//  Memory-mapped UART slave for the inter fabric (slave slot 2, 0x2000_0000). Replaces the
//  TX-only single-byte uart: buffered TX and RX FIFOs, runtime baud divisor, sticky error
//  flags and a level IRQ for the primary core. STATUS bit0 keeps legacy "tx ready" meaning.
// PARAMETERS
//  CLK_MHZ   12      core clock in MHz
//  BAUD      115200  reset baud rate; DIV_RST = CLK_MHZ*1_000_000/BAUD (104 at defaults)
//  TX_DEPTH  16      TX FIFO entries, power of two, >=2
//  RX_DEPTH  16      RX FIFO entries, power of two, >=2
// PORTS
//  clk              in   1   clock, all logic on posedge
//  reset            in   1   synchronous reset, active-high
//  slave_data_req_i in   1   access request
//  slave_data_we_i  in   1   1 = write
//  slave_data_be_i  in   4   byte enables
//  slave_data_addr_i in  32  byte address; only [3:2] decoded
//  slave_data_wdata_i in 32  write data
//  slave_data_gnt_o out  1   = req_i (always accepted same cycle)
//  slave_data_rvalid_o out 1 pulses 1 cycle after every accepted req (read or write)
//  slave_data_rdata_o out 32 registered read data, valid with rvalid_o, else 0
//  uart_tx          out  1   serial out, idle high
//  uart_rx          in   1   serial in, asynchronous
//  irq_o            out  1   level interrupt
// BEHAVIOUR
//  Reset: uart_tx=1, rvalid_o=0, rdata_o=0, irq_o=0, FIFOs empty, DIV=DIV_RST, IE=0, stickies 0.
//  Map (addr[3:2]): 0 DATA, 1 STATUS, 2 CTRL, 3 reserved (reads 0, writes ignored).
//  DATA wr (be[0]): push wdata[7:0] to TX FIFO; if full, drop and set TX_OVF.
//  DATA rd: {23'b0, ~rx_empty, rx_byte}; pops RX FIFO if non-empty; empty -> 0, no pop.
//  STATUS rd: [0] TX_READY=~tx_full [1] tx_empty [2] rx_valid [3] RX_OVR [4] FRAME_ERR
//   [5] TX_OVF [6] tx_idle (FIFO empty and FSM IDLE). [5:3] sticky, W1C on STATUS wr be[0].
//  CTRL: [15:0] DIV (be[0],be[1]), values <4 written as 4; [16] IE_RX, [17] IE_TX (be[2]).
//  irq_o (registered) = IE_RX&rx_valid | IE_TX&tx_empty | |sticky; updates 1 cycle after cause.
//  Read latency 1: rdata sampled on req cycle, presented with rvalid_o next cycle.
//  TX FSM: IDLE->START->DATA(8 bits LSB first)->STOP->IDLE/START; each state DIV cycles via
//   down-counter. IDLE pops FIFO when non-empty; back-to-back frames have no idle gap.
//   DIV change applies from next bit boundary.
//  RX: 2-flop sync; IDLE detects 1->0; START samples at DIV/2 (still 0 else abort to IDLE);
//   DATA samples every DIV; STOP sample: 1 -> push byte, 0 -> set FRAME_ERR, discard byte.
//   RX full at push -> drop byte, set RX_OVR. Same-cycle CPU pop + RX push on full FIFO:
//   both succeed, no overrun. Same-cycle TX pop + CPU push on full TX FIFO: push succeeds.
//  Reset mid-frame: frame abandoned, uart_tx=1 on the next cycle, FIFO contents lost.
//  Pointer widths $clog2(DEPTH)+1; wrap by natural overflow; full = MSB differ, rest equal.
// STRUCTURE
//  Package uart_mm_pkg: register offsets, STATUS/CTRL bit indices, TX/RX state encodings.
//  Sub-module sync_fifo #(WIDTH=8, DEPTH): push/pop/full/empty/dout (first-word fall-through);
//  instantiated as tx_fifo and rx_fifo. TX and RX FSMs and register file stay in uart_mm.
// TESTING
//  Reset, rd STATUS -> rdata 0x43 (TX_READY|tx_empty|tx_idle), uart_tx=1, DIV rd 104.
//  Wr DATA 0x55 -> uart_tx start at +1 cycle, bits 1,0,1,0,1,0,1,0, stop; 104 cycles each.
//  Wr 17 bytes fast (depth 16, 1 in FSM) -> none lost; 18th sets TX_OVF; W1C 0x20 clears it.
//  Drive 0xA5 on uart_rx at DIV=104 -> STATUS[2]=1, DATA rd 0x1A5, next DATA rd 0x000.
//  Frame with stop bit 0 -> FRAME_ERR=1, RX FIFO empty; 17 frames unread -> RX_OVR=1.
//  CTRL IE_RX=1, receive 0x3C -> irq_o high; DATA rd -> irq_o low 1 cycle after pop.

Source files
------------

// File: rtl/uart_mm_pkg.sv
// Shared register map, bit positions and FSM encodings for the memory-mapped UART.
package uart_mm_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_TX_READY  = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_VALID  = 2;
    localparam int ST_RX_OVR    = 3;
    localparam int ST_FRAME_ERR = 4;
    localparam int ST_TX_OVF    = 5;
    localparam int ST_TX_IDLE   = 6;

    localparam int CTRL_IE_RX = 16;
    localparam int CTRL_IE_TX = 17;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_mm_sync_fifo.sv
// First-word-fall-through FIFO; a push on a full FIFO succeeds when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/uart_mm.sv
// Memory-mapped UART slave: buffered TX/RX, runtime baud divisor, sticky errors, level IRQ.
// Bus access is always granted; reads return one cycle later with rvalid.
module uart_mm
    import uart_mm_pkg::*;
#(
    parameter int CLK_MHZ  = 12,
    parameter int BAUD     = 115200,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slave_data_req_i,
    input  logic        slave_data_we_i,
    input  logic [3:0]  slave_data_be_i,
    input  logic [31:0] slave_data_addr_i,
    input  logic [31:0] slave_data_wdata_i,
    output logic        slave_data_gnt_o,
    output logic        slave_data_rvalid_o,
    output logic [31:0] slave_data_rdata_o,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq_o
);
    localparam int          DIV_RST_I = CLK_MHZ * 1_000_000 / BAUD;
    localparam logic [15:0] DIV_RST   = 16'(DIV_RST_I);

    logic [1:0]  reg_sel;
    logic        wr_acc, rd_acc, ctrl_wr, clr_sticky;
    logic [15:0] div_q, div_d, div_wr, div_m1;
    logic        ie_rx_q, ie_tx_q;
    logic        rx_ovr_q, frame_err_q, tx_ovf_q, irq_q, rvalid_q;
    logic [31:0] rdata_q, rd_mux, status_w;
    logic        unused_ok;

    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_dout;
    logic        rx_push, rx_pop, rx_full, rx_empty, set_ferr;
    logic [7:0]  rx_dout;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic        tx_line_q, tx_line_d, tx_cnt_zero;

    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [1:0]  rx_sync_q;
    logic        rx_prev_q, rx_s, rx_cnt_zero;

    assign unused_ok = ^{slave_data_addr_i[31:4], slave_data_addr_i[1:0],
                         slave_data_be_i[3], slave_data_wdata_i[31:18]};

    assign reg_sel    = slave_data_addr_i[3:2];
    assign wr_acc     = slave_data_req_i && slave_data_we_i;
    assign rd_acc     = slave_data_req_i && !slave_data_we_i;
    assign ctrl_wr    = wr_acc && (reg_sel == REG_CTRL);
    assign clr_sticky = wr_acc && (reg_sel == REG_STATUS) && slave_data_be_i[0];
    assign tx_push    = wr_acc && (reg_sel == REG_DATA) && slave_data_be_i[0];
    assign rx_pop     = rd_acc && (reg_sel == REG_DATA) && !rx_empty;
    assign div_m1     = div_q - 16'd1;

    assign slave_data_gnt_o    = slave_data_req_i;
    assign slave_data_rvalid_o = rvalid_q;
    assign slave_data_rdata_o  = rdata_q;
    assign uart_tx             = tx_line_q;
    assign irq_o               = irq_q;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) tx_fifo (
        .clk(clk), .reset(reset), .push_i(tx_push), .pop_i(tx_pop),
        .din_i(slave_data_wdata_i[7:0]), .dout_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rx_fifo (
        .clk(clk), .reset(reset), .push_i(rx_push), .pop_i(rx_pop),
        .din_i(rx_sh_q), .dout_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty)
    );

    always_comb begin
        status_w               = '0;
        status_w[ST_TX_READY]  = !tx_full;
        status_w[ST_TX_EMPTY]  = tx_empty;
        status_w[ST_RX_VALID]  = !rx_empty;
        status_w[ST_RX_OVR]    = rx_ovr_q;
        status_w[ST_FRAME_ERR] = frame_err_q;
        status_w[ST_TX_OVF]    = tx_ovf_q;
        status_w[ST_TX_IDLE]   = tx_empty && (tx_state_q == TX_IDLE);
        case (reg_sel)
            REG_DATA:   rd_mux = {23'b0, !rx_empty, rx_empty ? 8'h00 : rx_dout};
            REG_STATUS: rd_mux = status_w;
            REG_CTRL:   rd_mux = {14'b0, ie_tx_q, ie_rx_q, div_q};
            default:    rd_mux = '0;
        endcase
    end

    // Divisors below 4 would leave the RX half-bit sample point degenerate.
    always_comb begin
        div_wr = div_q;
        if (slave_data_be_i[0]) div_wr[7:0]  = slave_data_wdata_i[7:0];
        if (slave_data_be_i[1]) div_wr[15:8] = slave_data_wdata_i[15:8];
        div_d = div_q;
        if (ctrl_wr && (slave_data_be_i[0] || slave_data_be_i[1]))
            div_d = (div_wr < DIV_MIN) ? DIV_MIN : div_wr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= DIV_RST;
            ie_rx_q     <= 1'b0;
            ie_tx_q     <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            tx_ovf_q    <= 1'b0;
            irq_q       <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            div_q <= div_d;
            if (ctrl_wr && slave_data_be_i[2]) begin
                ie_rx_q <= slave_data_wdata_i[CTRL_IE_RX];
                ie_tx_q <= slave_data_wdata_i[CTRL_IE_TX];
            end
            rx_ovr_q <= (rx_push && rx_full && !rx_pop) ||
                        (rx_ovr_q && !(clr_sticky && slave_data_wdata_i[ST_RX_OVR]));
            frame_err_q <= set_ferr ||
                        (frame_err_q && !(clr_sticky && slave_data_wdata_i[ST_FRAME_ERR]));
            tx_ovf_q <= (tx_push && tx_full && !tx_pop) ||
                        (tx_ovf_q && !(clr_sticky && slave_data_wdata_i[ST_TX_OVF]));
            irq_q    <= (ie_rx_q && !rx_empty) || (ie_tx_q && tx_empty) ||
                        rx_ovr_q || frame_err_q || tx_ovf_q;
            rvalid_q <= slave_data_req_i;
            rdata_q  <= rd_acc ? rd_mux : '0;
        end
    end

    // TX FSM: state register, next-state, outputs.
    assign tx_cnt_zero = (tx_cnt_q == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_line_q  <= tx_line_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        case (tx_state_q)
            TX_IDLE: if (!tx_empty) begin
                tx_state_d = TX_START;
                tx_cnt_d   = div_m1;
                tx_sh_d    = tx_dout;
            end
            TX_START: if (tx_cnt_zero) begin
                tx_state_d = TX_DATA;
                tx_cnt_d   = div_m1;
                tx_bit_d   = '0;
            end else tx_cnt_d = tx_cnt_q - 16'd1;
            TX_DATA: if (tx_cnt_zero) begin
                tx_cnt_d = div_m1;
                tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                else                  tx_bit_d   = tx_bit_q + 3'd1;
            end else tx_cnt_d = tx_cnt_q - 16'd1;
            TX_STOP: if (tx_cnt_zero) begin
                if (!tx_empty) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = div_m1;
                    tx_sh_d    = tx_dout;
                end else tx_state_d = TX_IDLE;
            end else tx_cnt_d = tx_cnt_q - 16'd1;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pop = !tx_empty && ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && tx_cnt_zero));
        case (tx_state_d)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_sh_d[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    // RX FSM on the synchronised line: state register, next-state, outputs.
    assign rx_s        = rx_sync_q[1];
    assign rx_cnt_zero = (rx_cnt_q == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_rx};
            rx_prev_q  <= rx_s;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_s) begin
                rx_state_d = RX_START;
                rx_cnt_d   = (div_q >> 1) - 16'd1;
            end
            RX_START: if (rx_cnt_zero) begin
                rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                rx_cnt_d   = div_m1;
                rx_bit_d   = '0;
            end else rx_cnt_d = rx_cnt_q - 16'd1;
            RX_DATA: if (rx_cnt_zero) begin
                rx_cnt_d = div_m1;
                rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q - 16'd1;
            RX_STOP: if (rx_cnt_zero) rx_state_d = RX_IDLE;
                     else             rx_cnt_d   = rx_cnt_q - 16'd1;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_push  = (rx_state_q == RX_STOP) && rx_cnt_zero && rx_s;
        set_ferr = (rx_state_q == RX_STOP) && rx_cnt_zero && !rx_s;
    end

endmodule

// File: tb/tb_uart_mm.sv
// Directed bench for uart_mm: register access, TX framing, RX framing, errors and IRQ.
module tb_uart_mm;
    localparam logic [31:0] A_DATA   = 32'h2000_0000;
    localparam logic [31:0] A_STATUS = 32'h2000_0004;
    localparam logic [31:0] A_CTRL   = 32'h2000_0008;
    localparam logic [31:0] A_RSVD   = 32'h2000_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        uart_tx, uart_rx, irq;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    uart_mm dut (
        .clk(clk), .reset(reset),
        .slave_data_req_i(req), .slave_data_we_i(we), .slave_data_be_i(be),
        .slave_data_addr_i(addr), .slave_data_wdata_i(wdata),
        .slave_data_gnt_o(gnt), .slave_data_rvalid_o(rvalid), .slave_data_rdata_o(rdata),
        .uart_tx(uart_tx), .uart_rx(uart_rx), .irq_o(irq)
    );

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk); req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
        @(negedge clk); req = 1'b0; we = 1'b0; be = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk); req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
        @(negedge clk); d = rdata; req = 1'b0; be = 4'h0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (div) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (div) @(negedge clk);
    endtask

    task automatic decode_frame(input int div, output logic [7:0] b, output logic ok);
        int t;
        t = 0; ok = 1'b1; b = 8'h00;
        while (uart_tx !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
        if (t >= 2000) ok = 1'b0;
        else begin
            repeat (div / 2) @(negedge clk);
            if (uart_tx !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (div) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (div) @(negedge clk);
            if (uart_tx !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0; uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL rst_tx: got %b want 1", uart_tx); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq); end
        n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL rst_bus: rvalid %b rdata %h want 0 0", rvalid, rdata); end
        reset = 1'b0;
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h43) begin n_err++; $display("FAIL rst_status: got %h want 43", d); end
        bus_read(A_CTRL, d);
        n_cmp++; if (d !== 32'h68) begin n_err++; $display("FAIL rst_ctrl: got %h want 68", d); end
        bus_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_RSVD, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rsvd_rd: got %h want 0", d); end
        bus_read(A_CTRL, d);
        n_cmp++; if (d !== 32'h68) begin n_err++; $display("FAIL rsvd_wr_ignored: got %h want 68", d); end
    endtask

    task automatic test_bus_ctrl;
        logic [31:0] d;
        @(negedge clk); req = 1'b1; we = 1'b0; addr = A_STATUS; be = 4'hF;
        n_cmp++; if (gnt !== 1'b1) begin n_err++; $display("FAIL gnt: got %b want 1", gnt); end
        @(negedge clk); req = 1'b0;
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h43) begin n_err++; $display("FAIL rd_lat: rvalid %b rdata %h want 1 43", rvalid, rdata); end
        @(negedge clk);
        n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin n_err++; $display("FAIL rd_idle: rvalid %b rdata %h want 0 0", rvalid, rdata); end
        bus_write(A_CTRL, 32'h0000_0002, 4'b0011);
        n_cmp++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin n_err++; $display("FAIL wr_rvalid: rvalid %b rdata %h want 1 0", rvalid, rdata); end
        bus_read(A_CTRL, d);
        n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL div_clamp: got %h want 4", d); end
        bus_write(A_CTRL, 32'h0003_1200, 4'b0010);
        bus_read(A_CTRL, d);
        n_cmp++; if (d !== 32'h1204) begin n_err++; $display("FAIL div_be1: got %h want 1204", d); end
        bus_write(A_CTRL, 32'h0000_0068, 4'b0011);
        bus_read(A_CTRL, d);
        n_cmp++; if (d !== 32'h68) begin n_err++; $display("FAIL div_restore: got %h want 68", d); end
    endtask

    task automatic test_tx_single;
        logic [7:0]  pat;
        logic [31:0] d;
        logic        exp;
        pat = 8'h55;
        bus_write(A_DATA, 32'h55, 4'b0001);
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL tx_pre: got %b want 1", uart_tx); end
        @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL tx_start: got %b want 0", uart_tx); end
        repeat (103) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL tx_start_len: got %b want 0", uart_tx); end
        @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL tx_bit0_edge: got %b want 1", uart_tx); end
        repeat (52) @(negedge clk);
        for (int j = 0; j < 9; j++) begin
            exp = (j < 8) ? pat[j] : 1'b1;
            n_cmp++; if (uart_tx !== exp) begin n_err++; $display("FAIL tx_bit%0d: got %b want %b", j, uart_tx, exp); end
            repeat (104) @(negedge clk);
        end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h43) begin n_err++; $display("FAIL tx_done_status: got %h want 43", d); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  got [17];
        logic        okv [17];
        logic [31:0] d;
        bus_write(A_CTRL, 32'h0000_0008, 4'b0011);
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    @(negedge clk); req = 1'b1; we = 1'b1; addr = A_DATA; be = 4'b0001; wdata = 32'hC0 + i;
                end
                @(negedge clk); req = 1'b0; we = 1'b0; be = 4'h0;
            end
            begin
                for (int i = 0; i < 17; i++) decode_frame(8, got[i], okv[i]);
            end
        join
        for (int i = 0; i < 17; i++) begin
            n_cmp++;
            if (!okv[i] || got[i] !== 8'(8'hC0 + i)) begin
                n_err++; $display("FAIL b2b_frame%0d: got %h ok %b want %h", i, got[i], okv[i], 8'(8'hC0 + i));
            end
        end
        repeat (20) @(negedge clk);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h63) begin n_err++; $display("FAIL tx_ovf_set: got %h want 63", d); end
        bus_write(A_STATUS, 32'h20, 4'b0001);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h43) begin n_err++; $display("FAIL tx_ovf_w1c: got %h want 43", d); end
        bus_write(A_CTRL, 32'h0000_0068, 4'b0011);
    endtask

    task automatic test_rx_basic;
        logic [31:0] d;
        send_frame(8'hA5, 1'b1, 104);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h47) begin n_err++; $display("FAIL rx_status: got %h want 47", d); end
        bus_read(A_DATA, d);
        n_cmp++; if (d !== 32'h1A5) begin n_err++; $display("FAIL rx_data: got %h want 1a5", d); end
        bus_read(A_DATA, d);
        n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL rx_empty_rd: got %h want 0", d); end
    endtask

    task automatic test_rx_errors;
        logic [31:0] d;
        bus_write(A_CTRL, 32'h0000_0010, 4'b0011);
        send_frame(8'h77, 1'b0, 16);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h53) begin n_err++; $display("FAIL ferr_status: got %h want 53", d); end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ferr_irq: got %b want 1", irq); end
        bus_write(A_STATUS, 32'h10, 4'b0001);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h43) begin n_err++; $display("FAIL ferr_w1c: got %h want 43", d); end
        for (int i = 0; i < 17; i++) send_frame(8'h40 + 8'(i), 1'b1, 16);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h4F) begin n_err++; $display("FAIL rx_ovr_status: got %h want 4f", d); end
        for (int i = 0; i < 16; i++) begin
            bus_read(A_DATA, d);
            n_cmp++; if (d !== 32'h140 + i) begin n_err++; $display("FAIL rx_ovr_data%0d: got %h want %h", i, d, 32'h140 + i); end
        end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h4B) begin n_err++; $display("FAIL rx_drained: got %h want 4b", d); end
        bus_write(A_STATUS, 32'h08, 4'b0001);
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h43) begin n_err++; $display("FAIL rx_ovr_w1c: got %h want 43", d); end
    endtask

    task automatic test_irq;
        bus_write(A_CTRL, 32'h0001_0010, 4'b0111);
        repeat (2) @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_quiet: got %b want 0", irq); end
        send_frame(8'h3C, 1'b1, 16);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rx: got %b want 1", irq); end
        @(negedge clk); req = 1'b1; we = 1'b0; addr = A_DATA; be = 4'hF;
        @(negedge clk); req = 1'b0;
        n_cmp++; if (rdata !== 32'h13C || irq !== 1'b1) begin n_err++; $display("FAIL irq_pop_cycle: rdata %h irq %b want 13c 1", rdata, irq); end
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        bus_write(A_DATA, 32'h00, 4'b0001);
        repeat (20) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL mid_tx_low: got %b want 0", uart_tx); end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL mid_rst_tx: got %b want 1", uart_tx); end
        reset = 1'b0;
        repeat (50) @(negedge clk);
        n_cmp++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL mid_rst_quiet: got %b want 1", uart_tx); end
        bus_read(A_STATUS, d);
        n_cmp++; if (d !== 32'h43) begin n_err++; $display("FAIL mid_rst_status: got %h want 43", d); end
        bus_read(A_CTRL, d);
        n_cmp++; if (d !== 32'h68) begin n_err++; $display("FAIL mid_rst_ctrl: got %h want 68", d); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_bus_ctrl;
        test_tx_single;
        test_back_to_back;
        test_rx_basic;
        test_rx_errors;
        test_irq;
        test_reset_midframe;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
